// File: rtl/vending_pkg.sv
// Shared definitions for the vending datapath (coin acceptor and change dispenser).
//   state_t     : change dispenser FSM states
//   coin_t      : coin selector for the hopper ejectors
//   NICKEL_VAL,
//   DIME_VAL    : coin values in nickel units
//   coin_value(): maps a coin_t to its value in nickel units
package vending_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SELECT     = 3'd1,
    PULSE      = 3'd2,
    WAIT_SENSE = 3'd3,
    DONE       = 3'd4
  } state_t;

  typedef enum logic {
    NICKEL = 1'b0,
    DIME   = 1'b1
  } coin_t;

  localparam logic [2:0] NICKEL_VAL = 3'd1;
  localparam logic [2:0] DIME_VAL   = 3'd2;

  function automatic logic [2:0] coin_value(input coin_t c);
    return (c == DIME) ? DIME_VAL : NICKEL_VAL;
  endfunction

endpackage

// File: rtl/vending_pulse_timer.sv
// Loadable down-counter shared by the eject pulse window and the drop-sensor
// timeout. Loading N makes 'last' assert on the N-th cycle after the load edge,
// so a phase that ends on 'last' lasts exactly N cycles.
// Ports:
//   clk      in  clock
//   reset_n  in  synchronous active-low reset (clears the counter)
//   load     in  load load_val this cycle (has priority over counting)
//   load_val in  W-bit reload value (>=1)
//   last     out counter is at 1: final cycle of the current window
module vending_pulse_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign last = (count == W'(1));

endmodule

// File: rtl/vending_change_dispenser.sv
// Change dispenser: pays a requested amount (nickel units) one coin at a time
// through the nickel/dime hopper ejectors, greedy dimes first, confirming each
// coin with the drop sensor. Tracks hopper inventory and reports paid/short.
// Optional feature macro: CHANGE_AUDIT_EN adds audit_total, a 16-bit wrapping
// lifetime count of nickel units paid.
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   req_valid/req_ready      change request handshake (ready only in IDLE)
//   req_amount               change owed, nickel units
//   eject_nickel/eject_dime  solenoid drives (registered, never both high)
//   coin_sensed              one-cycle pulse from the hopper drop sensor
//   load_valid/load_nickels/
//   load_dimes               inventory refill, honoured in IDLE only
//   done                     one-cycle completion pulse
//   paid_amount, short       result, valid with done, held until next accept
//   nickel_count/dime_count  current inventory
//   audit_total              (CHANGE_AUDIT_EN only) lifetime units paid
module vending_change_dispenser
  import vending_pkg::*;
#(
  parameter int CNT_W        = 4,
  parameter int NICKEL_INIT  = 10,
  parameter int DIME_INIT    = 10,
  parameter int PULSE_CYCLES = 4,
  parameter int ACK_TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_amount,
  output logic             eject_nickel,
  output logic             eject_dime,
  input  logic             coin_sensed,
  input  logic             load_valid,
  input  logic [CNT_W-1:0] load_nickels,
  input  logic [CNT_W-1:0] load_dimes,
  output logic             done,
  output logic [2:0]       paid_amount,
  output logic             short,
  output logic [CNT_W-1:0] nickel_count,
  output logic [CNT_W-1:0] dime_count
`ifdef CHANGE_AUDIT_EN
  ,
  output logic [15:0]      audit_total
`endif
);

  localparam int TMR_MAX = (PULSE_CYCLES > ACK_TIMEOUT) ? PULSE_CYCLES : ACK_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_CYCLES);
  localparam logic [TMR_W-1:0] ACK_LD   = TMR_W'(ACK_TIMEOUT);

  state_t           state;
  coin_t            coin;
  logic [2:0]       remaining;
  logic [2:0]       coin_val;
  logic             sel_dime;
  logic             sel_nickel;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_last;

  // Refill arithmetic clamps at the all-ones count instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign req_ready = (state == IDLE);
  assign coin_val  = coin_value(coin);

  // Greedy selection: a dime only when at least two units remain, so dimes
  // are never overpaid; a lone nickel remainder with no nickels ends short.
  always_comb begin
    sel_dime   = (remaining >= DIME_VAL) && (dime_count != '0);
    sel_nickel = !sel_dime && (remaining >= NICKEL_VAL) && (nickel_count != '0);
    tmr_load   = 1'b0;
    tmr_val    = PULSE_LD;
    if (state == SELECT && (sel_dime || sel_nickel)) begin
      tmr_load = 1'b1;
      tmr_val  = PULSE_LD;
    end else if (state == PULSE && tmr_last) begin
      tmr_load = 1'b1;
      tmr_val  = ACK_LD;
    end
  end

  vending_pulse_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .last     (tmr_last)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      coin         <= NICKEL;
      remaining    <= '0;
      eject_nickel <= 1'b0;
      eject_dime   <= 1'b0;
      done         <= 1'b0;
      paid_amount  <= '0;
      short        <= 1'b0;
      nickel_count <= CNT_W'(NICKEL_INIT);
      dime_count   <= CNT_W'(DIME_INIT);
`ifdef CHANGE_AUDIT_EN
      audit_total  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Refill lands in this cycle, so the following SELECT sees it.
          if (load_valid) begin
            nickel_count <= sat_add(nickel_count, load_nickels);
            dime_count   <= sat_add(dime_count, load_dimes);
          end
          if (req_valid) begin
            remaining   <= req_amount;
            paid_amount <= '0;
            short       <= 1'b0;
            state       <= SELECT;
          end
        end
        SELECT: begin
          if (sel_dime) begin
            coin       <= DIME;
            eject_dime <= 1'b1;
            state      <= PULSE;
          end else if (sel_nickel) begin
            coin         <= NICKEL;
            eject_nickel <= 1'b1;
            state        <= PULSE;
          end else begin
            done  <= 1'b1;
            short <= (remaining != '0);
            state <= DONE;
          end
        end
        PULSE: begin
          if (tmr_last) begin
            eject_nickel <= 1'b0;
            eject_dime   <= 1'b0;
            state        <= WAIT_SENSE;
          end
        end
        WAIT_SENSE: begin
          if (coin_sensed) begin
            if (coin == DIME) begin
              if (dime_count != '0) dime_count <= dime_count - CNT_W'(1);
            end else begin
              if (nickel_count != '0) nickel_count <= nickel_count - CNT_W'(1);
            end
            remaining   <= remaining - coin_val;
            paid_amount <= paid_amount + coin_val;
`ifdef CHANGE_AUDIT_EN
            audit_total <= audit_total + 16'(coin_val);
`endif
            state       <= SELECT;
          end else if (tmr_last) begin
            // No drop seen: treat that hopper as jammed/empty so SELECT
            // falls back to the other coin.
            if (coin == DIME) dime_count <= '0;
            else              nickel_count <= '0;
            state <= SELECT;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
